// File: rtl/bcd_mod_counter.sv
// ---------------------------------------------------------------------------
// bcd_mod_counter
//
// Registered BCD up/down modulo counter for the alarm-clock timekeeping path.
// The count runs over [MIN_VAL, MODULUS-1] in packed BCD. It wraps to the
// other end of the range when it steps past either end. Stages cascade by
// feeding one stage's tc into the next stage's en, so all stages step on the
// same edge.
//
// Parameters:
//   DIGITS   number of BCD digits; count is 4*DIGITS bits wide
//   MODULUS  one past the largest count value (MIN_VAL < MODULUS <= 10^DIGITS)
//   MIN_VAL  smallest count value and the up-count wrap target
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset (count -> MIN_VAL)
//   en        in   count-enable tick, one step per high cycle
//   up        in   1 = increment, 0 = decrement
//   load      in   parallel-load request (takes priority over en)
//   load_val  in   BCD value to load, least-significant digit in [3:0]
//   count     out  current BCD value (registered)
//   tc        out  combinational terminal count, intended for the next stage's en
//   wrap      out  one-cycle pulse after a wrap takes effect (registered)
//   load_err  out  one-cycle pulse after a rejected load (registered)
// ---------------------------------------------------------------------------
module bcd_mod_counter #(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 60,
    parameter int MIN_VAL = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  wrap,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    // Integer to packed BCD. This is only evaluated at elaboration, to build
    // the terminal constants. No binary value exists in the datapath.
    function automatic logic [W-1:0] to_bcd(input int value);
        int            v;
        logic [W-1:0]  r;
        v = value;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

    // Every nibble must be a decimal digit.
    function automatic logic is_bcd(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Digit-serial +1: a 9 rolls to 0 and carries into the next digit.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Digit-serial -1: a 0 rolls to 9 and borrows from the next digit.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [W-1:0] C_MIN = to_bcd(MIN_VAL);
    localparam logic [W-1:0] C_MAX = to_bcd(MODULUS - 1);

    logic [W-1:0] r_count;
    logic         r_wrap;
    logic         r_load_err;

    logic         w_at_max;
    logic         w_at_min;
    logic         w_load_ok;
    logic [W-1:0] w_inc;
    logic [W-1:0] w_dec;

    assign w_at_max = (r_count == C_MAX);
    assign w_at_min = (r_count == C_MIN);
    assign w_inc    = bcd_inc(r_count);
    assign w_dec    = bcd_dec(r_count);

    // When all nibbles are decimal digits, an unsigned compare of the packed
    // BCD word orders the same way as the decimal values. So the range check
    // can use the BCD constants directly.
    assign w_load_ok = is_bcd(load_val) && (load_val >= C_MIN) && (load_val <= C_MAX);

    assign tc = en & ~load & (up ? w_at_max : w_at_min);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count    <= C_MIN;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else if (load) begin
            r_wrap <= 1'b0;
            if (w_load_ok) begin
                r_count    <= load_val;
                r_load_err <= 1'b0;
            end else begin
                r_load_err <= 1'b1;
            end
        end else if (en) begin
            r_load_err <= 1'b0;
            if (up) begin
                r_count <= w_at_max ? C_MIN : w_inc;
                r_wrap  <= w_at_max;
            end else begin
                r_count <= w_at_min ? C_MAX : w_dec;
                r_wrap  <= w_at_min;
            end
        end else begin
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end
    end

    assign count    = r_count;
    assign wrap     = r_wrap;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_mod_counter
//
// Self-checking bench. It drives three counters:
//   - seconds (60/0)
//   - minutes (60/0), with en driven by the seconds stage's tc
//   - 12-hour hours (13/1)
// An integer reference model predicts count, tc, wrap and load_err for each
// counter. Directed steps come first, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_bcd_mod_counter;

    logic       clk;
    logic       rst_n;

    logic       s_en, s_up, s_load;
    logic [7:0] s_lv, s_count;
    logic       s_tc, s_wrap, s_lerr;

    logic       m_load;
    logic [7:0] m_lv, m_count;
    logic       m_tc, m_wrap, m_lerr;

    logic       h_en, h_up, h_load;
    logic [7:0] h_lv, h_count;
    logic       h_tc, h_wrap, h_lerr;

    int checks = 0;
    int errors = 0;

    // reference model state (decimal integers)
    int ms, mm, mh;
    bit sw, mw, hw, sle, mle, hle;

    bcd_mod_counter #(.DIGITS(2), .MODULUS(60), .MIN_VAL(0)) u_sec (
        .clk(clk), .rst_n(rst_n), .en(s_en), .up(s_up), .load(s_load),
        .load_val(s_lv), .count(s_count), .tc(s_tc), .wrap(s_wrap), .load_err(s_lerr)
    );

    bcd_mod_counter #(.DIGITS(2), .MODULUS(60), .MIN_VAL(0)) u_min (
        .clk(clk), .rst_n(rst_n), .en(s_tc), .up(s_up), .load(m_load),
        .load_val(m_lv), .count(m_count), .tc(m_tc), .wrap(m_wrap), .load_err(m_lerr)
    );

    bcd_mod_counter #(.DIGITS(2), .MODULUS(13), .MIN_VAL(1)) u_hr (
        .clk(clk), .rst_n(rst_n), .en(h_en), .up(h_up), .load(h_load),
        .load_val(h_lv), .count(h_count), .tc(h_tc), .wrap(h_wrap), .load_err(h_lerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic bit tcm(input int cur, input bit en, input bit ld, input bit up,
                               input int modv, input int minv);
        return en && !ld && (up ? (cur == modv - 1) : (cur == minv));
    endfunction

    function automatic int nxt(input int cur, input bit ld, input bit en, input bit up,
                               input logic [7:0] lv, input int modv, input int minv,
                               output bit w, output bit le);
        int d;
        w  = 1'b0;
        le = 1'b0;
        if (ld) begin
            if (lv[7:4] <= 4'd9 && lv[3:0] <= 4'd9) begin
                d = int'(lv[7:4]) * 10 + int'(lv[3:0]);
                if (d >= minv && d < modv) return d;
            end
            le = 1'b1;
            return cur;
        end
        if (en) begin
            if (up) begin
                if (cur == modv - 1) begin w = 1'b1; return minv; end
                return cur + 1;
            end else begin
                if (cur == minv) begin w = 1'b1; return modv - 1; end
                return cur - 1;
            end
        end
        return cur;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks tc against current inputs, advances one clock, then checks the
    // registered outputs.
    task automatic tick();
        bit ets, etm, eth;
        #1;
        ets = tcm(ms, s_en, s_load, s_up, 60, 0);
        etm = tcm(mm, ets, m_load, s_up, 60, 0);
        eth = tcm(mh, h_en, h_load, h_up, 13, 1);
        chk("sec_tc", {7'd0, s_tc}, {7'd0, ets});
        chk("min_tc", {7'd0, m_tc}, {7'd0, etm});
        chk("hr_tc",  {7'd0, h_tc}, {7'd0, eth});
        @(posedge clk);
        if (!rst_n) begin
            ms = 0; mm = 0; mh = 1;
            sw = 0; mw = 0; hw = 0; sle = 0; mle = 0; hle = 0;
        end else begin
            ms = nxt(ms, s_load, s_en, s_up, s_lv, 60, 0, sw, sle);
            mm = nxt(mm, m_load, ets, s_up, m_lv, 60, 0, mw, mle);
            mh = nxt(mh, h_load, h_en, h_up, h_lv, 13, 1, hw, hle);
        end
        #1;
        chk("sec_count", s_count, bcd2(ms));
        chk("sec_wrap",  {7'd0, s_wrap}, {7'd0, sw});
        chk("sec_lerr",  {7'd0, s_lerr}, {7'd0, sle});
        chk("min_count", m_count, bcd2(mm));
        chk("min_wrap",  {7'd0, m_wrap}, {7'd0, mw});
        chk("min_lerr",  {7'd0, m_lerr}, {7'd0, mle});
        chk("hr_count",  h_count, bcd2(mh));
        chk("hr_wrap",   {7'd0, h_wrap}, {7'd0, hw});
        chk("hr_lerr",   {7'd0, h_lerr}, {7'd0, hle});
    endtask

    task automatic idle();
        s_en = 0; s_load = 0; m_load = 0; h_en = 0; h_load = 0;
    endtask

    initial begin
        // Reset held for 3 cycles with en and load asserted.
        rst_n = 0;
        s_en = 1; s_up = 1; s_load = 1; s_lv = 8'h33;
        m_load = 1; m_lv = 8'h22;
        h_en = 1; h_up = 1; h_load = 1; h_lv = 8'h05;
        ms = 0; mm = 0; mh = 1;
        sw = 0; mw = 0; hw = 0; sle = 0; mle = 0; hle = 0;
        @(posedge clk);
        #1;
        tick();
        tick();
        rst_n = 1;
        idle();
        tick();
        chk("reset_sec", s_count, 8'h00);
        chk("reset_hr",  h_count, 8'h01);

        // Up-count wrap on seconds: 58, 59, 00, 01.
        s_load = 1; s_lv = 8'h57;
        tick();
        s_load = 0; s_en = 1; s_up = 1;
        tick();
        chk("up_58", s_count, 8'h58);
        tick();
        chk("up_59", s_count, 8'h59);
        chk("up_59_tc_live", {7'd0, s_tc}, 8'h01);
        tick();
        chk("up_00", s_count, 8'h00);
        chk("up_00_wrap", {7'd0, s_wrap}, 8'h01);
        tick();
        chk("up_01", s_count, 8'h01);
        chk("up_01_wrap", {7'd0, s_wrap}, 8'h00);
        idle();

        // 12-hour down-count wrap: 01, 12, 11.
        h_load = 1; h_lv = 8'h02;
        tick();
        h_load = 0; h_en = 1; h_up = 0;
        tick();
        chk("dn_01", h_count, 8'h01);
        tick();
        chk("dn_12", h_count, 8'h12);
        chk("dn_12_wrap", {7'd0, h_wrap}, 8'h01);
        tick();
        chk("dn_11", h_count, 8'h11);
        idle();

        // Load validation on seconds.
        s_load = 1; s_lv = 8'h5A;
        tick();
        chk("ld_5A_err", {7'd0, s_lerr}, 8'h01);
        s_lv = 8'h60;
        tick();
        chk("ld_60_err", {7'd0, s_lerr}, 8'h01);
        chk("ld_60_hold", s_count, 8'h01);
        s_lv = 8'h45;
        tick();
        chk("ld_45", s_count, 8'h45);
        chk("ld_45_err", {7'd0, s_lerr}, 8'h00);

        // Load beats enable at the terminal value.
        s_lv = 8'h59;
        tick();
        s_load = 1; s_lv = 8'h10; s_en = 1; s_up = 1;
        #1;
        chk("ld_vs_en_tc", {7'd0, s_tc}, 8'h00);
        tick();
        chk("ld_vs_en_cnt", s_count, 8'h10);
        chk("ld_vs_en_wrap", {7'd0, s_wrap}, 8'h00);
        idle();

        // Cascade: minutes 59, seconds 58 -> both roll to 00 together.
        s_load = 1; s_lv = 8'h58; m_load = 1; m_lv = 8'h59;
        tick();
        idle();
        s_en = 1; s_up = 1;
        tick();
        tick();
        chk("casc_sec", s_count, 8'h00);
        chk("casc_min", m_count, 8'h00);
        chk("casc_sec_wrap", {7'd0, s_wrap}, 8'h01);
        chk("casc_min_wrap", {7'd0, m_wrap}, 8'h01);
        idle();

        // Randomized run, including occasional mid-sequence reset.
        for (int i = 0; i < 400; i++) begin
            rst_n  = ($urandom_range(0, 40) != 0);
            s_en   = 1'($urandom_range(0, 1));
            s_up   = 1'($urandom_range(0, 1));
            s_load = ($urandom_range(0, 7) == 0);
            s_lv   = ($urandom_range(0, 1) != 0) ? bcd2($urandom_range(0, 59)) : 8'($urandom_range(0, 255));
            m_load = ($urandom_range(0, 15) == 0);
            m_lv   = ($urandom_range(0, 1) != 0) ? bcd2($urandom_range(0, 59)) : 8'($urandom_range(0, 255));
            h_en   = 1'($urandom_range(0, 1));
            h_up   = 1'($urandom_range(0, 1));
            h_load = ($urandom_range(0, 7) == 0);
            h_lv   = ($urandom_range(0, 1) != 0) ? bcd2($urandom_range(0, 14)) : 8'($urandom_range(0, 255));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_mod_counter.md
# bcd_mod_counter

Parametrised, registered BCD modulo counter for the alarm-clock timekeeping path. It generalises the combinational seconds incrementer into a clocked up/down counter with configurable digit count, modulus and minimum value. The counter supports enable, parallel load with validation, and a wrap pulse. Instances cascade as seconds (mod 60), minutes (mod 60), 24-h hours (mod 24, min 0) or 12-h hours (mod 13, min 1) by tying one stage's `tc` to the next stage's `en`.

## Interface
- `DIGITS`, default 2: number of BCD digits; the count is 4*DIGITS bits wide.
- `MODULUS`, default 60: one past the largest count value, as an integer. Must satisfy MIN_VAL < MODULUS <= 10^DIGITS.
- `MIN_VAL`, default 0: smallest count value and the wrap target when counting up.

Ports:
- `clk`  in  1  single clock; every register updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  count-enable tick: one step per cycle in which it is high.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `load`  in  1  parallel-load request.
- `load_val`  in  4*DIGITS  BCD value to load, least-significant digit in [3:0].
- `count`  out  4*DIGITS  current BCD value, registered.
- `tc`  out  1  combinational terminal count: `en & ~load & (up ? count==MODULUS-1 : count==MIN_VAL)`.
- `wrap`  out  1  registered pulse: high for the one cycle after a wrap takes effect.
- `load_err`  out  1  registered pulse: high for the one cycle after a rejected load.

## Operation
- Priority at each rising edge is `rst_n` low, then `load`, then `en`, then hold.
- Reset (`rst_n`=0 at the edge):
  - `count` becomes MIN_VAL in BCD.
  - `wrap` and `load_err` become 0.
  - `load` and `en` are ignored in that cycle.
- Load (`load`=1):
  - `load_val` is valid only if every nibble is <= 9 and its decimal value lies in [MIN_VAL, MODULUS-1].
  - Valid value: `count` becomes `load_val` and `load_err` becomes 0.
  - Invalid value: `count` holds and `load_err` becomes 1.
  - `en` is ignored in a load cycle, and `wrap` becomes 0.
- Count (`en`=1, `load`=0), counting up:
  - At MODULUS-1, `count` becomes MIN_VAL and `wrap` becomes 1.
  - Otherwise a BCD +1 ripples across the digits: a digit at 9 becomes 0 and carries into the next digit.
- Count (`en`=1, `load`=0), counting down:
  - At MIN_VAL, `count` becomes MODULUS-1 and `wrap` becomes 1.
  - Otherwise a BCD -1 ripples across the digits: a digit at 0 becomes 9 and borrows from the next digit.
- Idle (`en`=0, `load`=0): `count` holds, and `wrap` and `load_err` become 0.
- No binary conversion: arithmetic is digit-serial BCD, so no intermediate binary value exists. Terminal values are compared against BCD constants derived from the parameters at elaboration.
- `count` never leaves the set of valid BCD values in [MIN_VAL, MODULUS-1], even if `up` toggles every cycle.
- Cascading: the next stage's `en` is driven by this stage's `tc`. Both stages then update on the same edge, so no cycle of skew is introduced.

## Timing
- Latency of one cycle: an input sampled at edge N is visible on `count`, `wrap` and `load_err` after edge N.
- `tc` is purely combinational from `count`, `en`, `load` and `up`, with no register stage.
  - Its depth is one DIGITS-wide equality compare plus gating.
  - The full carry ripple across all digits must close within one clock period at DIGITS <= 4.
- `wrap` and `load_err` are never high for two consecutive cycles unless their cause repeats in consecutive cycles.
- Reset asserted in the middle of a count sequence takes effect at the next edge regardless of `en` or `load`. `tc` is 0 on the first cycle after reset unless MIN_VAL is the terminal value for the current `up` with `en`=1.

## Test plan
- Reset with DIGITS=2, MODULUS=60, MIN_VAL=0: hold `rst_n`=0 with `en`=1 and `load`=1 for 3 cycles, then release -> `count`=8'h00, `wrap`=0, `load_err`=0, and `count` stays 8'h00 through the reset cycles.
- Up-count wrap (60/0): load 8'h57, then `en`=1, `up`=1 for 4 cycles -> `count` reads 58, 59, 00, 01. `tc` is 1 only while `count`=59. `wrap`=1 only in the cycle showing 00.
- Down-count wrap in 12-h mode (MODULUS=13, MIN_VAL=1): load 8'h02, then `up`=0, `en`=1 for 3 cycles -> `count` reads 01, 12, 11. `wrap`=1 in the cycle showing 12.
- Load validation (60/0): load 8'h5A, then 8'h60 -> `count` unchanged and `load_err`=1 after each. Then load 8'h45 -> `count`=8'h45 and `load_err`=0.
- Load versus enable: with `count`=8'h59 and `up`=1, assert `load`=1 (`load_val`=8'h10) and `en`=1 together -> `tc`=0, `count`=8'h10, `wrap`=0.
- Cascade: seconds (60/0) drives minutes (60/0) through `tc`. Start at minutes=59 and seconds=58, then `en`=1 for 2 cycles -> after the second edge both read 00, with `wrap` high on both stages in the same cycle.
